// File: rtl/ahb_sram_resp.sv
// AHB-Lite slave responder: word-organised scratch memory with byte-lane writes,
// programmable data-phase wait states and the two-cycle ERROR response.
module ahb_sram_resp #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic        HREADYS,
    input  logic [31:0] HWDATAS,
    output logic        HREADYOUTS,
    output logic        HRESPS,
    output logic [31:0] HRDATAS
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  dp_valid, dp_valid_nxt;
    logic                  dp_write, dp_write_nxt;
    logic [ADDR_WIDTH-1:0] dp_addr, dp_addr_nxt;
    logic [3:0]            dp_be, dp_be_nxt;
    logic [31:0]           mem [DEPTH];

    logic       acc;
    logic       addr_err;
    logic       commit;
    logic [3:0] be_dec;
    logic [1:0] boff;
    logic       unused_bits;

    assign boff        = HADDRS[1:0];
    assign acc         = HSELS & HTRANSS[1] & HREADYS;
    assign unused_bits = ^{HADDRS[31:ADDR_WIDTH+2], HTRANSS[0]};

    // Size/alignment legality and byte-lane decode of the address phase
    always_comb begin
        be_dec   = 4'b1111;
        addr_err = 1'b0;
        case (HSIZES)
            3'd0:    be_dec = 4'b0001 << boff;
            3'd1: begin
                be_dec   = boff[1] ? 4'b1100 : 4'b0011;
                addr_err = boff[0];
            end
            3'd2:    addr_err = (boff != 2'b00);
            default: addr_err = 1'b1;
        endcase
    end

    // Next-state and output decode
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dp_valid_nxt = dp_valid;
        dp_write_nxt = dp_write;
        dp_addr_nxt  = dp_addr;
        dp_be_nxt    = dp_be;
        HREADYOUTS   = 1'b1;
        HRESPS       = 1'b0;

        case (state)
            ST_WAIT: begin
                HREADYOUTS = 1'b0;
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ST_ERR1: begin
                HREADYOUTS = 1'b0;
                HRESPS     = 1'b1;
                state_nxt  = ST_ERR2;
            end
            ST_ERR2: HRESPS = 1'b1;
            default: ;
        endcase

        // IDLE and ERR2 are the cycles that complete a data phase and may accept
        if (state == ST_IDLE || state == ST_ERR2) begin
            state_nxt    = ST_IDLE;
            dp_valid_nxt = 1'b0;
            if (acc) begin
                dp_write_nxt = HWRITES;
                dp_addr_nxt  = HADDRS[ADDR_WIDTH+1:2];
                dp_be_nxt    = be_dec;
                if (addr_err) begin
                    state_nxt = ST_ERR1;
                end else begin
                    dp_valid_nxt = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_be    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dp_valid <= dp_valid_nxt;
            dp_write <= dp_write_nxt;
            dp_addr  <= dp_addr_nxt;
            dp_be    <= dp_be_nxt;
        end
    end

    // A pending OKAY phase is in its final cycle once the FSM is back in IDLE
    assign commit = dp_valid & dp_write & (state == ST_IDLE);

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (dp_be[b]) mem[dp_addr][8*b +: 8] <= HWDATAS[8*b +: 8];
            end
        end
    end

    assign HRDATAS = (dp_valid & ~dp_write) ? mem[dp_addr] : 32'd0;

endmodule
